// File: rtl/regbank_read_port.sv
// Two-stage operand-fetch port for the 8x8 register bank, clocked on the falling edge.
// S1 holds register indices, S2 holds the operand pair. Same-edge bank writes are forwarded.
module regbank_read_port (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [7:0] R0,
   input  logic [7:0] R1,
   input  logic [7:0] R2,
   input  logic [7:0] R3,
   input  logic [7:0] R4,
   input  logic [7:0] R5,
   input  logic [7:0] R6,
   input  logic [7:0] R7,
   input  logic [2:0] RA,
   input  logic [2:0] RB,
   input  logic       REQ,
   output logic       RDY,
   output logic [7:0] OA,
   output logic [7:0] OB,
   output logic       VLD,
   input  logic       TAKE,
   input  logic       WE,
   input  logic [2:0] WS,
   input  logic [7:0] WD
);

   // Handshake: a request transfers on a falling edge where REQ & RDY. RDY never
   // depends on REQ. A pair leaves S2 on a falling edge where VLD & TAKE.
   logic       s1_v;
   logic [2:0] s1_a;
   logic [2:0] s1_b;

   logic       advance;
   logic       accept;
   logic       xfer;
   logic [7:0] bank [8];
   logic [7:0] fwd_a;
   logic [7:0] fwd_b;

   always_comb begin
      bank[0] = R0;
      bank[1] = R1;
      bank[2] = R2;
      bank[3] = R3;
      bank[4] = R4;
      bank[5] = R5;
      bank[6] = R6;
      bank[7] = R7;
   end

   assign advance = !VLD || TAKE;
   assign RDY     = !s1_v || advance;
   assign accept  = REQ && RDY;
   assign xfer    = s1_v && advance;

   // A write landing on the transfer edge wins over the bank's stale output.
   assign fwd_a = (WE && (WS == s1_a)) ? WD : bank[s1_a];
   assign fwd_b = (WE && (WS == s1_b)) ? WD : bank[s1_b];

   always_ff @(negedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         s1_v <= 1'b0;
         s1_a <= 3'd0;
         s1_b <= 3'd0;
      end else if (accept) begin
         s1_v <= 1'b1;
         s1_a <= RA;
         s1_b <= RB;
      end else if (xfer) begin
         s1_v <= 1'b0;
      end
   end

   always_ff @(negedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         VLD <= 1'b0;
         OA  <= 8'h00;
         OB  <= 8'h00;
      end else if (xfer) begin
         VLD <= 1'b1;
         OA  <= fwd_a;
         OB  <= fwd_b;
      end else if (VLD && TAKE) begin
         VLD <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regbank_read_port.sv
// Directed bench for regbank_read_port: each task drives one scenario and checks inline.
module tb_regbank_read_port;

   logic       CLK;
   logic       RSTn;
   logic [7:0] r_in [8];
   logic [2:0] RA;
   logic [2:0] RB;
   logic       REQ;
   logic       RDY;
   logic [7:0] OA;
   logic [7:0] OB;
   logic       VLD;
   logic       TAKE;
   logic       WE;
   logic [2:0] WS;
   logic [7:0] WD;

   int tests_run;
   int tests_failed;

   regbank_read_port dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .R0   (r_in[0]),
      .R1   (r_in[1]),
      .R2   (r_in[2]),
      .R3   (r_in[3]),
      .R4   (r_in[4]),
      .R5   (r_in[5]),
      .R6   (r_in[6]),
      .R7   (r_in[7]),
      .RA   (RA),
      .RB   (RB),
      .REQ  (REQ),
      .RDY  (RDY),
      .OA   (OA),
      .OB   (OB),
      .VLD  (VLD),
      .TAKE (TAKE),
      .WE   (WE),
      .WS   (WS),
      .WD   (WD)
   );

   // Clock starts high so the first falling edge is at t=5.
   initial CLK = 1'b1;
   always #5 CLK = ~CLK;

   // Advance past the next falling edge; outputs are then stable for sampling.
   task automatic step;
      @(negedge CLK);
      #1;
   endtask

   task automatic test_reset;
      #3;
      tests_run++; if (VLD !== 1'b0) begin tests_failed++; $display("FAIL reset_vld got=%b exp=0", VLD); end
      tests_run++; if (OA !== 8'h00) begin tests_failed++; $display("FAIL reset_oa got=%h exp=00", OA); end
      tests_run++; if (OB !== 8'h00) begin tests_failed++; $display("FAIL reset_ob got=%h exp=00", OB); end
      tests_run++; if (RDY !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy got=%b exp=1", RDY); end
      step;
      step;
      @(posedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic test_basic;
      TAKE = 1'b1;
      r_in[3] = 8'h5A;
      r_in[6] = 8'hC3;
      RA = 3'd3; RB = 3'd6; REQ = 1'b1;
      step;
      REQ = 1'b0;
      tests_run++; if (VLD !== 1'b0) begin tests_failed++; $display("FAIL basic_latency_vld got=%b exp=0", VLD); end
      step;
      tests_run++; if (VLD !== 1'b1) begin tests_failed++; $display("FAIL basic_vld got=%b exp=1", VLD); end
      tests_run++; if (OA !== 8'h5A) begin tests_failed++; $display("FAIL basic_oa got=%h exp=5a", OA); end
      tests_run++; if (OB !== 8'hC3) begin tests_failed++; $display("FAIL basic_ob got=%h exp=c3", OB); end
      step;
      tests_run++; if (VLD !== 1'b0) begin tests_failed++; $display("FAIL basic_drain_vld got=%b exp=0", VLD); end
      tests_run++; if (OA !== 8'h5A) begin tests_failed++; $display("FAIL basic_hold_oa got=%h exp=5a", OA); end
   endtask

   task automatic test_forward;
      TAKE = 1'b1;
      r_in[2] = 8'h11;
      RA = 3'd2; RB = 3'd2; REQ = 1'b1;
      step;
      REQ = 1'b0;
      WE = 1'b1; WS = 3'd2; WD = 8'h7E;
      step;
      WE = 1'b0;
      tests_run++; if (OA !== 8'h7E) begin tests_failed++; $display("FAIL fwd_hit_oa got=%h exp=7e", OA); end
      tests_run++; if (OB !== 8'h7E) begin tests_failed++; $display("FAIL fwd_hit_ob got=%h exp=7e", OB); end
      REQ = 1'b1;
      step;
      REQ = 1'b0;
      WE = 1'b1; WS = 3'd5; WD = 8'h7E;
      step;
      WE = 1'b0;
      tests_run++; if (OA !== 8'h11) begin tests_failed++; $display("FAIL fwd_miss_oa got=%h exp=11", OA); end
      tests_run++; if (OB !== 8'h11) begin tests_failed++; $display("FAIL fwd_miss_ob got=%h exp=11", OB); end
      step;
      tests_run++; if (VLD !== 1'b0) begin tests_failed++; $display("FAIL fwd_drain_vld got=%b exp=0", VLD); end
   endtask

   task automatic test_backpressure;
      r_in[1] = 8'h01; r_in[4] = 8'h04; r_in[7] = 8'h07;
      TAKE = 1'b0;
      RA = 3'd1; RB = 3'd1; REQ = 1'b1;
      step;
      tests_run++; if (RDY !== 1'b1) begin tests_failed++; $display("FAIL bp_rdy_after_first got=%b exp=1", RDY); end
      RA = 3'd4; RB = 3'd4;
      step;
      tests_run++; if (RDY !== 1'b0) begin tests_failed++; $display("FAIL bp_rdy_after_second got=%b exp=0", RDY); end
      tests_run++; if (OA !== 8'h01 || VLD !== 1'b1) begin tests_failed++; $display("FAIL bp_first_pair got=%h/%b exp=01/1", OA, VLD); end
      RA = 3'd7; RB = 3'd7;
      step;
      tests_run++; if (OA !== 8'h01 || RDY !== 1'b0) begin tests_failed++; $display("FAIL bp_stalled got=%h/%b exp=01/0", OA, RDY); end
      TAKE = 1'b1;
      #1;
      tests_run++; if (RDY !== 1'b1) begin tests_failed++; $display("FAIL bp_recover_rdy got=%b exp=1", RDY); end
      step;
      REQ = 1'b0;
      tests_run++; if (OA !== 8'h04 || OB !== 8'h04 || VLD !== 1'b1) begin tests_failed++; $display("FAIL bp_second_pair got=%h/%h/%b exp=04/04/1", OA, OB, VLD); end
      step;
      tests_run++; if (OA !== 8'h07 || OB !== 8'h07 || VLD !== 1'b1) begin tests_failed++; $display("FAIL bp_third_pair got=%h/%h/%b exp=07/07/1", OA, OB, VLD); end
      step;
      tests_run++; if (VLD !== 1'b0) begin tests_failed++; $display("FAIL bp_empty_vld got=%b exp=0", VLD); end
   endtask

   task automatic test_snapshot;
      r_in[0] = 8'h20;
      TAKE = 1'b0;
      RA = 3'd0; RB = 3'd0; REQ = 1'b1;
      step;
      REQ = 1'b0;
      step;
      tests_run++; if (OA !== 8'h20 || VLD !== 1'b1) begin tests_failed++; $display("FAIL snap_load got=%h/%b exp=20/1", OA, VLD); end
      r_in[0] = 8'h99;
      WE = 1'b1; WS = 3'd0; WD = 8'h99;
      step;
      WE = 1'b0;
      step;
      tests_run++; if (OA !== 8'h20 || OB !== 8'h20) begin tests_failed++; $display("FAIL snap_hold got=%h/%h exp=20/20", OA, OB); end
      TAKE = 1'b1;
      step;
      tests_run++; if (VLD !== 1'b0) begin tests_failed++; $display("FAIL snap_drain got=%b exp=0", VLD); end
      REQ = 1'b1;
      step;
      REQ = 1'b0;
      step;
      tests_run++; if (OA !== 8'h99 || VLD !== 1'b1) begin tests_failed++; $display("FAIL snap_fresh got=%h/%b exp=99/1", OA, VLD); end
      step;
   endtask

   task automatic test_simultaneous;
      r_in[1] = 8'h01; r_in[4] = 8'h04; r_in[7] = 8'h07;
      r_in[3] = 8'h5A; r_in[6] = 8'hC3;
      TAKE = 1'b0;
      RA = 3'd1; RB = 3'd4; REQ = 1'b1;
      step;
      RA = 3'd7; RB = 3'd7;
      step;
      tests_run++; if (OA !== 8'h01 || OB !== 8'h04 || RDY !== 1'b0) begin tests_failed++; $display("FAIL sim_setup got=%h/%h/%b exp=01/04/0", OA, OB, RDY); end
      TAKE = 1'b1;
      RA = 3'd3; RB = 3'd6;
      step;
      REQ = 1'b0;
      tests_run++; if (VLD !== 1'b1 || OA !== 8'h07 || OB !== 8'h07) begin tests_failed++; $display("FAIL sim_transfer got=%b/%h/%h exp=1/07/07", VLD, OA, OB); end
      tests_run++; if (dut.s1_v !== 1'b1 || dut.s1_a !== 3'd3 || dut.s1_b !== 3'd6) begin tests_failed++; $display("FAIL sim_accept got=%b/%0d/%0d exp=1/3/6", dut.s1_v, dut.s1_a, dut.s1_b); end
      step;
      tests_run++; if (OA !== 8'h5A || OB !== 8'hC3 || VLD !== 1'b1) begin tests_failed++; $display("FAIL sim_next_pair got=%h/%h/%b exp=5a/c3/1", OA, OB, VLD); end
      step;
   endtask

   task automatic test_async_reset;
      TAKE = 1'b0;
      RA = 3'd1; RB = 3'd4; REQ = 1'b1;
      step;
      RA = 3'd7; RB = 3'd7;
      step;
      REQ = 1'b0;
      tests_run++; if (VLD !== 1'b1 || dut.s1_v !== 1'b1) begin tests_failed++; $display("FAIL arst_setup got=%b/%b exp=1/1", VLD, dut.s1_v); end
      #2;
      RSTn = 1'b0;
      #1;
      tests_run++; if (VLD !== 1'b0 || OA !== 8'h00 || OB !== 8'h00) begin tests_failed++; $display("FAIL arst_outputs got=%b/%h/%h exp=0/00/00", VLD, OA, OB); end
      tests_run++; if (RDY !== 1'b1 || dut.s1_v !== 1'b0) begin tests_failed++; $display("FAIL arst_rdy got=%b/%b exp=1/0", RDY, dut.s1_v); end
      step;
      @(posedge CLK);
      RSTn = 1'b1;
      TAKE = 1'b1;
      step;
      tests_run++; if (VLD !== 1'b0) begin tests_failed++; $display("FAIL arst_release1 got=%b exp=0", VLD); end
      step;
      tests_run++; if (VLD !== 1'b0 || OA !== 8'h00) begin tests_failed++; $display("FAIL arst_release2 got=%b/%h exp=0/00", VLD, OA); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      RSTn = 1'b0;
      for (int i = 0; i < 8; i++) r_in[i] = 8'(i);
      RA = 3'd0; RB = 3'd0; REQ = 1'b0; TAKE = 1'b0;
      WE = 1'b0; WS = 3'd0; WD = 8'h00;
      test_reset;
      test_basic;
      test_forward;
      test_backpressure;
      test_snapshot;
      test_simultaneous;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
